sync_barrier_ctrl: RTL

// Central responder for the proc sync-barrier handshake. Each proc core issues a one-cycle

---
 rtl/sync_barrier_ctrl.sv | 86 ++++++++
 1 files changed

// File: rtl/sync_barrier_ctrl.sv
// sync_barrier_ctrl: collects per-core barrier requests and releases all masked participants together
module sync_barrier_ctrl #(
  parameter int N_CORES            = 4,
  parameter int SYNC_BARRIER_WIDTH = 8,
  parameter int TIMEOUT_WIDTH      = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [N_CORES*SYNC_BARRIER_WIDTH-1:0] sync_barrier,
  input  logic [N_CORES-1:0]                    sync_req,
  input  logic                                  cfg_we,
  input  logic [SYNC_BARRIER_WIDTH-1:0]         cfg_id,
  input  logic [N_CORES-1:0]                    cfg_mask,
  input  logic [TIMEOUT_WIDTH-1:0]              timeout_val,
  output logic [N_CORES-1:0]                    sync_enable,
  output logic                                  busy,
  output logic [2:0]                            err_status,
  output logic [SYNC_BARRIER_WIDTH-1:0]         err_id
);
  localparam int SB_W = SYNC_BARRIER_WIDTH;
  typedef enum logic [1:0] {IDLE, FETCH, COLLECT, RELEASE} state_t;
  state_t state;
  logic [N_CORES-1:0] mask_tab [2**SB_W];
  logic [SB_W-1:0] ids [N_CORES];
  logic [SB_W-1:0] active_id, sel_id, dup_id;
  logic [N_CORES-1:0] valid, trig, mask_r, cand, arrived, dup, clr;
  logic [TIMEOUT_WIDTH-1:0] tcnt;
  logic mask_err, done, tmo;
  logic [2:0] err_set;
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (cfg_we) mask_tab[cfg_id] <= cfg_mask;
  // a request sampled this edge competes for the trigger slot with the id it carries
  always_comb begin
    cand = valid | sync_req;
    dup = valid & sync_req;
    arrived = '0;
    sel_id = '0;
    dup_id = '0;
    for (int k = N_CORES - 1; k >= 0; k--) begin
      arrived[k] = valid[k] && ids[k] == active_id;
      if (cand[k]) sel_id = valid[k] ? ids[k] : sync_barrier[k*SB_W +: SB_W];
      if (dup[k]) dup_id = sync_barrier[k*SB_W +: SB_W];
    end
    mask_err = state == COLLECT && (trig & mask_r) == '0;
    done = state == COLLECT && !mask_err && (arrived & mask_r) == mask_r;
    tmo = state == COLLECT && !mask_err && !done && timeout_val != '0 && tcnt == timeout_val;
    err_set = {tmo, mask_err, |dup};
    clr = mask_err ? trig : state == RELEASE ? mask_r : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      valid <= '0;
      sync_enable <= '0;
      err_status <= '0;
      err_id <= '0;
      tcnt <= '0;
    end else begin
      valid <= (valid & ~clr) | (sync_req & ~valid);
      for (int k = 0; k < N_CORES; k++)
        if (sync_req[k] && !valid[k]) ids[k] <= sync_barrier[k*SB_W +: SB_W];
      sync_enable <= state == RELEASE ? mask_r : '0;
      err_status <= err_status | err_set;
      if (err_status == '0 && err_set != '0) err_id <= err_set[0] ? dup_id : active_id;
      case (state)
        IDLE:
          if (|cand) begin
            active_id <= sel_id;
            trig <= cand & (~cand + N_CORES'(1));
            state <= FETCH;
          end
        FETCH: begin
          mask_r <= mask_tab[active_id];
          tcnt <= '0;
          state <= COLLECT;
        end
        COLLECT: begin
          state <= (mask_err || tmo) ? IDLE : done ? RELEASE : COLLECT;
          if (!(&tcnt)) tcnt <= tcnt + TIMEOUT_WIDTH'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
